// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and defaults for the CPU run sequencer.
// Holds the state encoding and a helper that sizes the small counters.
package cpu_run_ctrl_pkg;

  localparam int unsigned PROG_W_DEF = 2;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned ST_W       = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_NEXT   = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_w_for(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between the run sequencer, its requester and the CPU core.
// The slave side is the sequencer; the master side is the requester plus CPU.
interface cpu_run_ctrl_if #(
  parameter int unsigned PROG_W = 2,
  parameter int unsigned CNT_W  = 16
);

  logic              Go;
  logic [PROG_W:0]   NumProgs;
  logic              CpuAck;
  logic              CpuReset;
  logic              CpuStart;
  logic [PROG_W-1:0] ProgSel;
  logic              Busy;
  logic [CNT_W-1:0]  CycleCount;
  logic              CountValid;
  logic              Done;
  logic              Timeout;

  modport slave (
    input  Go, NumProgs, CpuAck,
    output CpuReset, CpuStart, ProgSel, Busy, CycleCount, CountValid, Done, Timeout
  );

  modport master (
    output Go, NumProgs, CpuAck,
    input  CpuReset, CpuStart, ProgSel, Busy, CycleCount, CountValid, Done, Timeout
  );

endinterface

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Up-counter with synchronous clear that stops at LIMIT instead of wrapping.
// o_at_limit_c is a combinational decode of the registered count.
module sat_counter
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned W     = CNT_W_DEF,
  parameter int unsigned LIMIT = 32'h0000_FFFF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_at_limit_c
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LIM)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count      = r_count;
  assign o_at_limit_c = (r_count == LIM);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run sequencer for the CPU core: on Go, launches programs 0..NumProgs-1 in turn,
// times each run from start release to Ack and aborts the batch on watchdog expiry.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned PROG_W     = PROG_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned RST_CYCLES = 1,
  parameter int unsigned MAX_CYCLES = 32'h0000_FFFF
) (
  input  logic           Clk,
  input  logic           Reset,
  cpu_run_ctrl_if.slave  bus
);

  localparam logic [ST_W-1:0] S_IDLE   = ST_IDLE;
  localparam logic [ST_W-1:0] S_LAUNCH = ST_LAUNCH;
  localparam logic [ST_W-1:0] S_RUN    = ST_RUN;
  localparam logic [ST_W-1:0] S_NEXT   = ST_NEXT;
  localparam logic [ST_W-1:0] S_FINISH = ST_FINISH;

  localparam int unsigned      NUM_W     = PROG_W + 1;
  localparam int unsigned      LCH_W     = cnt_w_for(RST_CYCLES - 1);
  localparam logic [NUM_W-1:0] MAX_PROGS = NUM_W'(1) << PROG_W;

  logic [ST_W-1:0]   r_state;
  logic [NUM_W-1:0]  r_num;
  logic [PROG_W-1:0] r_prog_sel;
  logic              r_cpu_reset;
  logic              r_cpu_start;
  logic              r_busy;
  logic [CNT_W-1:0]  r_cycle_count;
  logic              r_count_valid;
  logic              r_done;
  logic              r_timeout;

  logic [ST_W-1:0]   w_nxt_state;
  logic [NUM_W-1:0]  w_nxt_num;
  logic [PROG_W-1:0] w_nxt_prog_sel;
  logic              w_nxt_launch;
  logic              w_nxt_busy;
  logic [CNT_W-1:0]  w_nxt_cycle_count;
  logic              w_nxt_count_valid;
  logic              w_nxt_done;
  logic              w_nxt_timeout;

  logic [LCH_W-1:0]  w_unused_lch_count;
  logic              w_lch_at_limit;
  logic [CNT_W-1:0]  w_wd_count;
  logic              w_wd_at_limit;

  // Launch counter: holds CpuReset/CpuStart for RST_CYCLES cycles.
  sat_counter #(
    .W     (LCH_W),
    .LIMIT (RST_CYCLES - 1)
  ) u_launch_cnt (
    .clk          (Clk),
    .rst_n        (Reset),
    .i_clr        (r_state != S_LAUNCH),
    .i_en         (r_state == S_LAUNCH),
    .o_count      (w_unused_lch_count),
    .o_at_limit_c (w_lch_at_limit)
  );

  // Run/watchdog counter: zero in the first RUN cycle, saturates at MAX_CYCLES.
  sat_counter #(
    .W     (CNT_W),
    .LIMIT (MAX_CYCLES)
  ) u_wd_cnt (
    .clk          (Clk),
    .rst_n        (Reset),
    .i_clr        (r_state != S_RUN),
    .i_en         (r_state == S_RUN),
    .o_count      (w_wd_count),
    .o_at_limit_c (w_wd_at_limit)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state       <= S_IDLE;
      r_num         <= '0;
      r_prog_sel    <= '0;
      r_cpu_reset   <= 1'b1;
      r_cpu_start   <= 1'b1;
      r_busy        <= 1'b0;
      r_cycle_count <= '0;
      r_count_valid <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_num         <= w_nxt_num;
      r_prog_sel    <= w_nxt_prog_sel;
      r_cpu_reset   <= w_nxt_launch;
      r_cpu_start   <= w_nxt_launch;
      r_busy        <= w_nxt_busy;
      r_cycle_count <= w_nxt_cycle_count;
      r_count_valid <= w_nxt_count_valid;
      r_done        <= w_nxt_done;
      r_timeout     <= w_nxt_timeout;
    end
  end

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_num         = r_num;
    w_nxt_prog_sel    = r_prog_sel;
    w_nxt_cycle_count = r_cycle_count;
    w_nxt_count_valid = 1'b0;
    w_nxt_done        = 1'b0;
    w_nxt_timeout     = r_timeout;

    case (r_state)
      S_IDLE: begin
        if (bus.Go) begin
          if (bus.NumProgs != '0) begin
            // Requests beyond the addressable program range are clamped.
            w_nxt_state    = S_LAUNCH;
            w_nxt_num      = (bus.NumProgs > MAX_PROGS) ? MAX_PROGS : bus.NumProgs;
            w_nxt_prog_sel = '0;
            w_nxt_timeout  = 1'b0;
          end else begin
            w_nxt_done = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        if (w_lch_at_limit) begin
          w_nxt_state = S_RUN;
        end
      end
      S_RUN: begin
        // Ack takes priority over a watchdog hit in the same cycle.
        if (bus.CpuAck) begin
          w_nxt_state       = S_NEXT;
          w_nxt_cycle_count = w_wd_count;
          w_nxt_count_valid = 1'b1;
        end else if (w_wd_at_limit) begin
          w_nxt_state       = S_FINISH;
          w_nxt_cycle_count = w_wd_count;
          w_nxt_count_valid = 1'b1;
          w_nxt_timeout     = 1'b1;
        end
      end
      S_NEXT: begin
        if ((NUM_W'(r_prog_sel) + NUM_W'(1)) == r_num) begin
          w_nxt_state = S_FINISH;
        end else begin
          w_nxt_prog_sel = r_prog_sel + PROG_W'(1);
          w_nxt_state    = S_LAUNCH;
        end
      end
      S_FINISH: begin
        w_nxt_state = S_IDLE;
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase

    if (w_nxt_state == S_FINISH) begin
      w_nxt_done = 1'b1;
    end
    w_nxt_launch = (w_nxt_state == S_LAUNCH);
    w_nxt_busy   = (w_nxt_state != S_IDLE);
  end

  assign bus.CpuReset   = r_cpu_reset;
  assign bus.CpuStart   = r_cpu_start;
  assign bus.ProgSel    = r_prog_sel;
  assign bus.Busy       = r_busy;
  assign bus.CycleCount = r_cycle_count;
  assign bus.CountValid = r_count_valid;
  assign bus.Done       = r_done;
  assign bus.Timeout    = r_timeout;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: a CPU model acks after a chosen delay,
// a batch-level reference predicts strobes, and a monitor compares them.
module tb_cpu_run_ctrl;

  localparam int unsigned PROG_W     = 2;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned RST_CYCLES = 1;
  localparam int unsigned MAX_CYC    = 20;
  localparam int          NEVER      = 1000;

  typedef struct {
    int count;
    int prog;
    int tmo;
  } cnt_exp_t;

  typedef struct {
    int prog;
    int tmo;
    int busy;
  } done_exp_t;

  logic Clk;
  logic Reset;

  cpu_run_ctrl_if #(.PROG_W(PROG_W), .CNT_W(CNT_W)) bus ();

  cpu_run_ctrl #(
    .PROG_W     (PROG_W),
    .CNT_W      (CNT_W),
    .RST_CYCLES (RST_CYCLES),
    .MAX_CYCLES (MAX_CYC)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  cnt_exp_t  cnt_q[$];
  done_exp_t done_q[$];
  int        delay_q[$];

  int m_timeout = 0;
  int m_prog = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Batch-level reference: each program either acks within the limit or ends the batch.
  task automatic model_push(input int n, input int dl[4]);
    if (n == 0) begin
      done_q.push_back('{prog: m_prog, tmo: m_timeout, busy: 0});
    end else begin
      m_timeout = 0;
      for (int i = 0; i < n; i++) begin
        delay_q.push_back(dl[i]);
        m_prog = i;
        if (dl[i] <= int'(MAX_CYC)) begin
          cnt_q.push_back('{count: dl[i], prog: i, tmo: 0});
        end else begin
          cnt_q.push_back('{count: int'(MAX_CYC), prog: i, tmo: 1});
          m_timeout = 1;
          break;
        end
      end
      done_q.push_back('{prog: m_prog, tmo: m_timeout, busy: 1});
    end
  endtask

  // CPU model: ack rises once `delay` cycles have passed since start release.
  int  cur_delay = NEVER;
  int  k_cyc = 0;
  bit  in_launch = 1'b0;
  int  hi_cnt = 0;
  int  st_cnt = 0;

  always @(negedge Clk) begin
    if (!Reset) begin
      bus.CpuAck = 1'b0;
      in_launch  = 1'b0;
      hi_cnt     = 0;
      st_cnt     = 0;
      k_cyc      = 0;
    end else if (bus.CpuReset && bus.Busy) begin
      if (!in_launch) begin
        in_launch = 1'b1;
        cur_delay = (delay_q.size() != 0) ? delay_q.pop_front() : NEVER;
        hi_cnt    = 0;
        st_cnt    = 0;
      end
      hi_cnt++;
      if (bus.CpuStart) st_cnt++;
      k_cyc      = 0;
      bus.CpuAck = 1'b0;
    end else begin
      if (in_launch) begin
        in_launch = 1'b0;
        chk("launch_reset_len", hi_cnt, RST_CYCLES);
        chk("launch_start_len", st_cnt, RST_CYCLES);
      end
      if (bus.CpuReset) begin
        k_cyc      = 0;
        bus.CpuAck = 1'b0;
      end else begin
        bus.CpuAck = (k_cyc >= cur_delay);
        k_cyc++;
      end
    end
  end

  cnt_exp_t  ce;
  done_exp_t de;

  // Monitor: pops one expectation per CountValid / Done strobe.
  always @(negedge Clk) begin
    if (Reset) begin
      if (bus.CountValid) begin
        if (cnt_q.size() == 0) begin
          chk("unexpected_count_valid", bus.CountValid, 0);
        end else begin
          ce = cnt_q.pop_front();
          chk("cycle_count", bus.CycleCount, ce.count);
          chk("count_prog_sel", bus.ProgSel, ce.prog);
          chk("count_timeout", bus.Timeout, ce.tmo);
        end
      end
      if (bus.Done) begin
        done_seen++;
        if (done_q.size() == 0) begin
          chk("unexpected_done", bus.Done, 0);
        end else begin
          de = done_q.pop_front();
          chk("done_prog_sel", bus.ProgSel, de.prog);
          chk("done_timeout", bus.Timeout, de.tmo);
          chk("done_busy", bus.Busy, de.busy);
        end
      end
    end
  end

  task automatic run_batch(input int n, input int dl[4], input bit inject);
    int inj_at;
    @(negedge Clk);
    chk("idle_before_go", bus.Busy, 0);
    model_push(n, dl);
    bus.Go       = 1'b1;
    bus.NumProgs = 3'(n);
    @(negedge Clk);
    bus.Go       = 1'b0;
    bus.NumProgs = 3'($urandom_range(0, 7));
    if (n != 0) begin
      chk("go_latency_cpu_reset", bus.CpuReset, 1);
      chk("go_busy", bus.Busy, 1);
    end else begin
      chk("noop_busy", bus.Busy, 0);
    end
    inj_at = int'($urandom_range(1, 40));
    for (int c = 0; c < 600; c++) begin
      if (cnt_q.size() == 0 && done_q.size() == 0) break;
      if (inject && c == inj_at && bus.Busy && !bus.Done) begin
        bus.Go       = 1'b1;
        bus.NumProgs = 3'($urandom_range(1, 4));
      end else begin
        bus.Go = 1'b0;
      end
      @(negedge Clk);
    end
    bus.Go = 1'b0;
    chk("batch_complete", cnt_q.size() + done_q.size(), 0);
    cnt_q.delete();
    done_q.delete();
    delay_q.delete();
  endtask

  initial begin
    int dl[4];
    int n;
    bit found;
    int done_before;

    Reset        = 1'b0;
    bus.Go       = 1'b0;
    bus.NumProgs = '0;

    repeat (3) @(negedge Clk);
    chk("rst_cpu_reset", bus.CpuReset, 1);
    chk("rst_cpu_start", bus.CpuStart, 1);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_prog_sel", bus.ProgSel, 0);
    chk("rst_cycle_count", bus.CycleCount, 0);
    chk("rst_count_valid", bus.CountValid, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_timeout", bus.Timeout, 0);

    @(posedge Clk);
    #2 Reset = 1'b1;
    repeat (10) @(negedge Clk);
    chk("idle_cpu_reset", bus.CpuReset, 0);
    chk("idle_cpu_start", bus.CpuStart, 0);
    chk("idle_busy", bus.Busy, 0);
    chk("idle_no_done", done_seen, 0);

    run_batch(1, '{10, 0, 0, 0}, 1'b0);
    run_batch(3, '{4, 7, 2, 0}, 1'b0);
    run_batch(2, '{NEVER, 5, 0, 0}, 1'b0);
    chk("timeout_sticky", bus.Timeout, 1);
    run_batch(0, '{0, 0, 0, 0}, 1'b0);
    run_batch(2, '{int'(MAX_CYC), 0, 0, 0}, 1'b0);
    chk("timeout_cleared", bus.Timeout, 0);

    for (int b = 0; b < 14; b++) begin
      n = int'($urandom_range(0, 4));
      for (int i = 0; i < 4; i++) dl[i] = int'($urandom_range(0, 23));
      run_batch(n, dl, 1'b1);
    end

    // Async reset in the middle of program 1, with a stray Go while busy.
    @(negedge Clk);
    model_push(3, '{3, 15, 5, 0});
    bus.Go       = 1'b1;
    bus.NumProgs = 3'd3;
    @(negedge Clk);
    bus.Go = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus.ProgSel == 2'd1 && !bus.CpuReset && bus.Busy) begin
        found = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    chk("reached_prog1_run", found, 1);
    repeat (3) @(negedge Clk);
    bus.Go       = 1'b1;
    bus.NumProgs = 3'd2;
    @(negedge Clk);
    bus.Go = 1'b0;
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk("mid_rst_cpu_reset", bus.CpuReset, 1);
    chk("mid_rst_cpu_start", bus.CpuStart, 1);
    chk("mid_rst_prog_sel", bus.ProgSel, 0);
    chk("mid_rst_busy", bus.Busy, 0);
    chk("mid_rst_cycle_count", bus.CycleCount, 0);
    chk("mid_rst_done", bus.Done, 0);
    chk("mid_rst_timeout", bus.Timeout, 0);
    cnt_q.delete();
    done_q.delete();
    delay_q.delete();
    m_timeout   = 0;
    m_prog      = 0;
    done_before = done_seen;
    repeat (2) @(negedge Clk);
    @(posedge Clk);
    #2 Reset = 1'b1;
    repeat (30) @(negedge Clk);
    chk("no_done_after_mid_reset", done_seen - done_before, 0);
    chk("post_rst_busy", bus.Busy, 0);
    chk("post_rst_cpu_reset", bus.CpuReset, 0);

    run_batch(2, '{5, 6, 0, 0}, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
